// File: rtl/tdm_pkg.sv
// tdm_pkg: shared types and helpers for the TDM demultiplexer.
//   state_e  : framing state (HUNT waits for start-of-frame, COLLECT assembles)
//   ERRCNT_W : width of the optional framing-error counter
//   idx_w()  : channel index width for a given channel count
package tdm_pkg;

   typedef enum logic {
      HUNT    = 1'b0,
      COLLECT = 1'b1
   } state_e;

   localparam int unsigned ERRCNT_W = 8;

   // Index width; clamped to 1 so a degenerate count still yields a legal vector.
   function automatic int unsigned idx_w(input int unsigned channels);
      return (channels < 2) ? 1 : $clog2(channels);
   endfunction

endpackage

// File: rtl/tdm_chan_counter.sv
// tdm_chan_counter: modulo-CHANNELS channel index counter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (index resets to 0)
//   en         : advance the index by one, wrapping CHANNELS-1 -> 0
//   load       : synchronous load of 1 (start-of-frame sample occupies lane 0)
//   idx        : current channel index (registered)
//   last_c     : combinational wrap flag, high while idx == CHANNELS-1
module tdm_chan_counter
   import tdm_pkg::*;
#(
   parameter int unsigned CHANNELS = 4,
   localparam int unsigned IDX_W   = idx_w(CHANNELS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             load,
   output logic [IDX_W-1:0] idx,
   output logic             last_c
);

   logic [IDX_W-1:0] idx_q;
   logic [IDX_W-1:0] idx_d;

   assign last_c = (idx_q == IDX_W'(CHANNELS - 1));
   assign idx    = idx_q;

   // Load has priority: a start-of-frame always restarts the index at 1.
   always_comb begin
      idx_d = idx_q;
      if (load) begin
         idx_d = IDX_W'(1);
      end else if (en) begin
         idx_d = last_c ? '0 : idx_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q <= '0;
      end else begin
         idx_q <= idx_d;
      end
   end

endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: time-division demultiplexer. Steers a serial stream of WIDTH-bit
// samples, framed by in_sof, into CHANNELS lanes and presents each complete
// frame as one parallel word with a valid/ready handshake.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : sample handshake (in_ready is combinational from out_ready)
//   in_sof              : marks the current sample as channel 0
//   in_data [WIDTH]     : sample
//   out_valid/out_ready : frame handshake
//   out_data [CH*WIDTH] : channel k at bits [k*WIDTH +: WIDTH]
//   frame_err           : one-cycle pulse when in_sof arrives mid-frame
//   err_cnt [8]         : saturating framing-error count (only with TDM_DEMUX_ERRCNT_EN)
// Build option: define TDM_DEMUX_ERRCNT_EN to add err_cnt.
module tdm_demux
   import tdm_pkg::*;
#(
   parameter int unsigned WIDTH    = 1,
   parameter int unsigned CHANNELS = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   input  logic                      in_sof,
   input  logic [WIDTH-1:0]          in_data,
   output logic                      in_ready,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [CHANNELS*WIDTH-1:0] out_data,
   output logic                      frame_err
`ifdef TDM_DEMUX_ERRCNT_EN
   ,
   output logic [ERRCNT_W-1:0]       err_cnt
`endif
);

   localparam int unsigned FRAME_W = CHANNELS * WIDTH;
   localparam int unsigned IDX_W   = idx_w(CHANNELS);

   state_e             state_q;
   state_e             state_d;
   logic [IDX_W-1:0]   idx;
   logic               last_c;
   logic               acc_c;
   logic               cnt_en_c;
   logic               cnt_load_c;
   logic [31:0]        lane_lo_c;
   logic [FRAME_W-1:0] asm_q;
   logic [FRAME_W-1:0] asm_d;
   logic [FRAME_W-1:0] out_data_q;
   logic [FRAME_W-1:0] out_data_d;
   logic               out_valid_q;
   logic               out_valid_d;
   logic               frame_err_q;
   logic               frame_err_d;

   // Stall only the frame-completing sample while the previous frame is unclaimed.
   assign in_ready   = !((state_q == COLLECT) && last_c && out_valid_q && !out_ready);
   assign acc_c      = in_valid && in_ready;
   assign cnt_load_c = acc_c && in_sof;
   assign cnt_en_c   = acc_c && !in_sof && (state_q == COLLECT);
   assign lane_lo_c  = 32'(idx) * WIDTH;

   tdm_chan_counter #(
      .CHANNELS (CHANNELS)
   ) u_chan_counter (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (cnt_en_c),
      .load   (cnt_load_c),
      .idx    (idx),
      .last_c (last_c)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= HUNT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: leave HUNT on the first accepted start-of-frame, then stay in COLLECT.
   always_comb begin
      state_d = state_q;
      if ((state_q == HUNT) && acc_c && in_sof) begin
         state_d = COLLECT;
      end
   end

   // Lane steering, output register load and framing-error detection.
   always_comb begin
      asm_d       = asm_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      frame_err_d = 1'b0;
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
      if (acc_c && in_sof) begin
         asm_d[0 +: WIDTH] = in_data;
         frame_err_d       = (state_q == COLLECT) && (idx != '0);
      end else if (acc_c && (state_q == COLLECT)) begin
         asm_d[lane_lo_c +: WIDTH] = in_data;
         if (last_c) begin
            out_data_d  = asm_d;
            out_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         asm_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         asm_q       <= asm_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign frame_err = frame_err_q;

`ifdef TDM_DEMUX_ERRCNT_EN
   logic [ERRCNT_W-1:0] err_cnt_q;
   logic [ERRCNT_W-1:0] err_cnt_d;

   // Counts alongside the frame_err pulse; sticks at all-ones.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (frame_err_d && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + ERRCNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: scoreboard bench for tdm_demux (WIDTH=1, CHANNELS=4).
// A frame-level reference model pushes expected frames into a queue; a
// separate monitor pops and compares whenever the DUT hands over a frame.
// Define TDM_DEMUX_ERRCNT_EN to also cover err_cnt.
module tb_tdm_demux;

   localparam int unsigned W  = 1;
   localparam int unsigned CH = 4;

   logic            clk;
   logic            rst_n;
   logic            in_valid;
   logic            in_sof;
   logic [W-1:0]    in_data;
   logic            in_ready;
   logic            out_valid;
   logic            out_ready;
   logic [CH*W-1:0] out_data;
   logic            frame_err;
`ifdef TDM_DEMUX_ERRCNT_EN
   logic [7:0]      err_cnt;
`endif

   tdm_demux #(
      .WIDTH    (W),
      .CHANNELS (CH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_sof    (in_sof),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .frame_err (frame_err)
`ifdef TDM_DEMUX_ERRCNT_EN
      ,
      .err_cnt   (err_cnt)
`endif
   );

   int checks = 0;
   int errors = 0;

   // Reference model state: frames awaiting hand-over, samples of the frame in
   // progress, whether we are still hunting for a start-of-frame.
   logic [CH*W-1:0] exp_q[$];
   logic [W-1:0]    cur[$];
   bit              hunting   = 1'b1;
   bit              exp_ferr  = 1'b0;
   int              exp_errcnt = 0;
   logic [CH*W-1:0] mon_e;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      cur.delete();
      hunting    = 1'b1;
      exp_ferr   = 1'b0;
      exp_errcnt = 0;
   endtask

   // Model: evaluated just before each rising edge with the inputs of that cycle.
   task automatic model_step();
      bit              exp_rdy;
      bit              ferr;
      logic [CH*W-1:0] w;
      exp_rdy = !(!hunting && (cur.size() == CH - 1) && (exp_q.size() != 0) && !out_ready);
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      ferr = 1'b0;
      if (in_valid && exp_rdy) begin
         if (in_sof) begin
            if (!hunting && (cur.size() != 0)) ferr = 1'b1;
            cur.delete();
            cur.push_back(in_data);
            hunting = 1'b0;
         end else if (!hunting) begin
            cur.push_back(in_data);
            if (cur.size() == CH) begin
               w = '0;
               foreach (cur[k]) w[k*W +: W] = cur[k];
               exp_q.push_back(w);
               cur.delete();
            end
         end
      end
      exp_ferr = ferr;
      if (ferr && (exp_errcnt < 255)) exp_errcnt++;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         #4;
         if (rst_n) model_step();
      end
   end

   // Monitor: checks registered outputs mid-cycle, pops on each frame hand-over.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rst_n) begin
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_frame actual=%0h expected=none t=%0t", out_data, $time);
               end else begin
                  mon_e = exp_q.pop_front();
                  chk("out_data", 32'(out_data), 32'(mon_e));
               end
            end
            chk("frame_err", 32'(frame_err), 32'(exp_ferr));
`ifdef TDM_DEMUX_ERRCNT_EN
            chk("err_cnt", 32'(err_cnt), 32'(exp_errcnt));
`endif
         end
      end
   end

   task automatic drive(input bit v, input bit s, input logic [W-1:0] d, input bit r);
      @(negedge clk);
      in_valid  = v;
      in_sof    = s;
      in_data   = d;
      out_ready = r;
   endtask

   // Asynchronous reset pulse; outputs must clear without waiting for a clock edge.
   task automatic do_reset();
      @(negedge clk);
      in_valid  = 1'b0;
      in_sof    = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      rst_n     = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_out_data", 32'(out_data), 32'(0));
      chk("rst_in_ready", 32'(in_ready), 32'(1));
      chk("rst_frame_err", 32'(frame_err), 32'(0));
`ifdef TDM_DEMUX_ERRCNT_EN
      chk("rst_err_cnt", 32'(err_cnt), 32'(0));
`endif
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_sof    = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      do_reset();

      // Basic frame 1(sof),0,1,1 -> 1101.
      drive(1, 1, 1, 1);
      drive(1, 0, 0, 1);
      drive(1, 0, 1, 1);
      drive(1, 0, 1, 1);
      drive(0, 0, 0, 0);
      #2;
      chk("basic_valid", 32'(out_valid), 32'(1));
      chk("basic_data", 32'(out_data), 32'(4'b1101));
      drive(0, 0, 0, 1);

      // Hunt: two samples without sof dropped, then 0(sof),1,0,0 -> 0010.
      do_reset();
      drive(1, 0, 1, 1);
      drive(1, 0, 1, 1);
      drive(1, 1, 0, 1);
      drive(1, 0, 1, 1);
      drive(1, 0, 0, 1);
      drive(1, 0, 0, 1);
      drive(0, 0, 0, 0);
      #2;
      chk("hunt_data", 32'(out_data), 32'(4'b0010));
      drive(0, 0, 0, 1);

      // Mid-frame sof: 1(sof),1 then 0(sof),0,1,1 -> error pulse, 1100.
      do_reset();
      drive(1, 1, 1, 1);
      drive(1, 0, 1, 1);
      drive(1, 1, 0, 1);
      drive(0, 0, 0, 1);
      #2;
      chk("mid_ferr_pulse", 32'(frame_err), 32'(1));
      drive(1, 0, 0, 1);
      #2;
      chk("mid_ferr_clear", 32'(frame_err), 32'(0));
      drive(1, 0, 1, 1);
      drive(1, 0, 1, 1);
      drive(0, 0, 0, 0);
      #2;
      chk("mid_data", 32'(out_data), 32'(4'b1100));
`ifdef TDM_DEMUX_ERRCNT_EN
      chk("mid_err_cnt", 32'(err_cnt), 32'(1));
`endif
      drive(0, 0, 0, 1);

      // Backpressure: 1,0,0,0 held, then 0,0,0,1 stalls on its last sample.
      do_reset();
      drive(1, 1, 1, 0);
      drive(1, 0, 0, 0);
      drive(1, 0, 0, 0);
      drive(1, 0, 0, 0);
      drive(1, 1, 0, 0);
      drive(1, 0, 0, 0);
      drive(1, 0, 0, 0);
      drive(1, 0, 1, 0);
      #2;
      chk("bp_in_ready", 32'(in_ready), 32'(0));
      chk("bp_hold", 32'(out_data), 32'(4'b0001));
      drive(1, 0, 1, 0);
      drive(1, 0, 1, 1);
      drive(0, 0, 0, 0);
      #2;
      chk("bp_reload_valid", 32'(out_valid), 32'(1));
      chk("bp_reload_data", 32'(out_data), 32'(4'b1000));
      drive(0, 0, 0, 1);

      // Reset mid-frame with a frame pending; the next non-sof sample is dropped.
      do_reset();
      drive(1, 1, 0, 0);
      drive(1, 0, 1, 0);
      drive(1, 0, 1, 0);
      drive(1, 0, 1, 0);
      drive(1, 1, 1, 0);
      drive(1, 0, 1, 0);
      do_reset();
      drive(1, 0, 1, 1);
      drive(0, 0, 0, 1);
      #2;
      chk("rst_drop", 32'(out_valid), 32'(0));
      drive(0, 0, 0, 1);

      // Randomized traffic with gaps, stray sofs and random backpressure.
      do_reset();
      repeat (3000) begin
         drive($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 15,
               W'($urandom), $urandom_range(0, 99) < 60);
      end
      drive(0, 0, 0, 1);
      drive(0, 0, 0, 1);

`ifdef TDM_DEMUX_ERRCNT_EN
      // Saturation: 260 back-to-back mid-frame sofs.
      do_reset();
      repeat (261) drive(1, 1, 0, 1);
      drive(0, 0, 0, 1);
      #2;
      chk("sat_err_cnt", 32'(err_cnt), 32'(255));
`endif

      drive(0, 0, 0, 1);
      drive(0, 0, 0, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer: the receive-side counterpart of the team's 2:1/N:1 multiplexer blocks. It accepts a serial, time-multiplexed stream of WIDTH-bit samples framed by a start-of-frame marker, steers each sample to its channel lane, and presents one complete frame as a parallel word with a valid/ready handshake. It sits between a muxed link and the per-channel logic units.

## Interface
- WIDTH, default 1: sample width in bits.
- CHANNELS, default 4: samples per frame; legal range 2..16.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  sample present on in_data.
- in_sof  input  1  qualifies the current sample as channel 0; meaningful only with in_valid.
- in_data  input  WIDTH  sample.
- in_ready  output  1  sample accepted when in_valid && in_ready.
- out_valid  output  1  out_data holds a complete frame.
- out_ready  input  1  consumer takes the frame when out_valid && out_ready.
- out_data  output  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- frame_err  output  1  one-cycle pulse on a framing error.

## Operation
- States: HUNT (waiting for in_sof) and COLLECT (assembling a frame). Channel index idx runs 0..CHANNELS-1.
- HUNT: accepted samples without in_sof are dropped. An accepted sample with in_sof writes lane 0, sets idx=1, and enters COLLECT.
- COLLECT: an accepted sample writes assembly lane idx, then idx increments. On idx==CHANNELS-1, the assembly register plus the final sample are copied into the output register, out_valid is set, idx wraps to 0, and the state stays COLLECT. The next sample is channel 0 with or without in_sof.
- in_sof in COLLECT with idx!=0: the partial frame is discarded, the sample is written as lane 0, idx=1, and frame_err pulses. in_sof with idx==0 is normal.
- Backpressure: in_ready=0 only when state==COLLECT && idx==CHANNELS-1 && out_valid && !out_ready. Otherwise in_ready=1. in_ready has a combinational path from out_ready.
- Output register: loaded only on frame completion. It holds its value while out_valid && !out_ready. A drain and a new completion in the same cycle reload the register, and out_valid stays 1.
- Reset values: state HUNT, idx 0, out_valid 0, out_data 0, assembly register 0, frame_err 0, in_ready 1.

## Timing
- Last sample accepted at edge n: out_valid=1 and out_data updated after edge n, visible in cycle n+1. No cycle is lost between frames.
- out_valid falls on the edge where out_valid && out_ready, unless a frame completes on that same edge.
- frame_err is registered: it is high for exactly the cycle after the offending sample.
- rst_n asserted mid-frame: all state clears immediately and asynchronously. The partial frame is lost, and out_valid is 0 even if a frame was pending. After deassertion the block is in HUNT.
- Samples with in_valid=0 do not advance idx. Gaps are allowed anywhere.

## Configuration
- TDM_DEMUX_ERRCNT_EN defined: adds output err_cnt [7:0], reset 0. It increments on every frame_err pulse and saturates at 255.
- Undefined: the port and counter are absent. Framing behaviour is identical.

## Structure
- Shared package tdm_pkg holds:
  - the state enum (HUNT, COLLECT);
  - the ERRCNT_W=8 constant;
  - a function giving the index width as clog2(CHANNELS).
- One sub-module, tdm_chan_counter: modulo-CHANNELS counter with enable, synchronous load-to-1 (used on sof), wrap flag, and asynchronous active-low reset.
- Lane steering, output register and handshake stay in tdm_demux.

## Test plan
All scenarios use WIDTH=1, CHANNELS=4.
- Basic frame: rst_n low then high; samples 1(sof),0,1,1 on consecutive cycles with out_ready=1 -> out_data=4'b1101, out_valid high one cycle after the 4th sample; frame_err never set.
- Hunt: samples 1,1 without sof, then 0(sof),1,0,0 -> first two dropped; out_data=4'b0010.
- Mid-frame sof: 1(sof),1, then 0(sof),0,1,1 -> frame_err pulses once, cycle after the 3rd sample; out_data=4'b1100. With TDM_DEMUX_ERRCNT_EN, err_cnt=1.
- Backpressure: two back-to-back frames 1,0,0,0 and 0,0,0,1 with out_ready=0 -> out_data=4'b0001... first frame holds (out_data=4'b0001); in_ready=0 while the 4th sample of frame 2 is presented. Raise out_ready for one cycle -> 4'b1000 loads on that edge and out_valid stays 1.
- Reset mid-frame: after samples 1(sof),1, pulse rst_n low -> out_valid=0, out_data=0 immediately; a following sample without sof is dropped.
- Saturation (ERRCNT build): 260 mid-frame sof errors -> err_cnt=255.
